// File: rtl/pmd901_spi_ctrl.sv
// pmd901_spi_ctrl: SPI mode-0 speed-command master plus park/bend pin control for the PMD901.
// Optional build macro PMD901_SPI_CTRL_DEDUP_EN skips frames that repeat the last transmitted word.
module pmd901_spi_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_speed,
    input  logic              park_req,
    input  logic              bend_req,
    output logic              park,
    output logic              bend,
    output logic              spi_csn,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              fault,
    input  logic              fan,
    input  logic              ready,
    output logic              spi_violated,
    output logic              close2overheat,
    output logic              overheat,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               csn_q, csn_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;
    logic               park_q, park_d;
    logic               bend_q, bend_d;
    logic [2:0]         stat_meta_q, stat_meta_d;
    logic [2:0]         stat_sync_q, stat_sync_d;
    logic               accept_s, dup_hit_s, start_s, cnt_zero_s;
    logic [DATA_W-1:0]  shreg_nxt_s;

`ifdef PMD901_SPI_CTRL_DEDUP_EN
    logic [DATA_W-1:0]  last_q, last_d;
    logic               last_vld_q, last_vld_d;

    // A repeat of the last transmitted word is acknowledged without a frame.
    always_comb begin
        dup_hit_s = 1'b0;
        if (last_vld_q && (cmd_speed == last_q)) begin
            dup_hit_s = 1'b1;
        end else begin
            dup_hit_s = 1'b0;
        end
    end

    // Remember the last word sent; forget it when the device powers down.
    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (park_q && !park_d) begin
            last_vld_d = 1'b0;
        end else if (start_s) begin
            last_d     = cmd_speed;
            last_vld_d = 1'b1;
        end else begin
            last_vld_d = last_vld_q;
        end
    end

    // Stored-word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= {DATA_W{1'b0}};
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup_hit_s = 1'b0;
`endif

    assign cmd_ready      = (state_q == ST_IDLE) && park_q;
    assign busy           = (state_q != ST_IDLE);
    assign accept_s       = cmd_valid && cmd_ready;
    assign start_s        = accept_s && !dup_hit_s;
    assign cnt_zero_s     = (cnt_q == {CNT_W{1'b0}});
    assign shreg_nxt_s    = shreg_q << 1;
    assign spi_csn        = csn_q;
    assign spi_sclk       = sclk_q;
    assign spi_mosi       = mosi_q;
    assign done           = done_q;
    assign park           = park_q;
    assign bend           = bend_q;
    assign spi_violated   = stat_sync_q[2];
    assign close2overheat = stat_sync_q[1];
    assign overheat       = stat_sync_q[0];

    // Frame sequencer: every state lasts a multiple of CLK_DIV cycles timed by cnt_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        csn_d   = csn_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_RELOAD;
                    shreg_d = cmd_speed;
                    csn_d   = 1'b0;
                    mosi_d  = cmd_speed[DATA_W-1];
                end else if (dup_hit_s && accept_s) begin
                    done_d = 1'b1;
                end else begin
                    csn_d  = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = {BIT_W{1'b0}};
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_zero_s) begin
                    cnt_d  = CNT_RELOAD;
                    sclk_d = !sclk_q;
                    // Data advances only on the falling edge; the last bit is held through HOLD.
                    if (sclk_q && (bit_q == BIT_LAST)) begin
                        state_d = ST_HOLD;
                    end else if (sclk_q) begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shreg_nxt_s;
                        mosi_d  = shreg_nxt_s[DATA_W-1];
                    end else begin
                        bit_d = bit_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_RELOAD;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Pin control: park only moves outside a frame, bend only while chip select is high.
    always_comb begin
        park_d      = park_q;
        bend_d      = bend_q;
        stat_meta_d = {fault, fan, ready};
        stat_sync_d = stat_meta_q;
        if (((state_q == ST_IDLE) && !accept_s) || (state_q == ST_GAP)) begin
            park_d = park_req;
        end else begin
            park_d = park_q;
        end
        if (csn_q) begin
            bend_d = bend_req;
        end else begin
            bend_d = bend_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_q       <= {BIT_W{1'b0}};
            shreg_q     <= {DATA_W{1'b0}};
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            park_q      <= 1'b0;
            bend_q      <= 1'b0;
            stat_meta_q <= 3'b000;
            stat_sync_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
            park_q      <= park_d;
            bend_q      <= bend_d;
            stat_meta_q <= stat_meta_d;
            stat_sync_q <= stat_sync_d;
        end
    end

endmodule

// File: tb/tb_pmd901_spi_ctrl.sv
// Directed self-checking bench for pmd901_spi_ctrl with CLK_DIV=4, DATA_W=16.
// Cycle k=1 is the cycle right after the accepting clock edge T0.
module tb_pmd901_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_speed = 16'h0000;
    logic        park_req = 1'b0;
    logic        bend_req = 1'b0;
    logic        park, bend, spi_csn, spi_sclk, spi_mosi;
    logic        fault = 1'b0, fan = 1'b0, dev_ready = 1'b0;
    logic        spi_violated, close2overheat, overheat, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    int csn_first, csn_last, csn_rise_k, csn_fall2_k, rise_first, rises;
    int done_k, done_cnt, ready_k, mosi_viol, busy_cnt, bend_k, park_fall_k;
    logic [31:0] cap;
    logic [10:0] rst_snap;
    int act_speed_k, act_drop_valid_k, act_bend_k, act_park_k, act_rst_k;
    logic [15:0] act_speed_val;
    bit ok;

    pmd901_spi_ctrl #(.CLK_DIV(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed), .park_req(park_req), .bend_req(bend_req),
        .park(park), .bend(bend), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .fault(fault), .fan(fan), .ready(dev_ready),
        .spi_violated(spi_violated), .close2overheat(close2overheat),
        .overheat(overheat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acts();
        act_speed_k = -1; act_drop_valid_k = -1; act_bend_k = -1;
        act_park_k = -1; act_rst_k = -1; act_speed_val = 16'h0000;
    endtask

    task automatic send_accept(input logic [15:0] w, input bit hold, output bit acc);
        cmd_speed = w;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (cmd_ready) acc = 1'b1;
            tick();
        end
        if (!hold) cmd_valid = 1'b0;
        check_eq("accept", acc, 1'b1);
    endtask

    // Observe ncyc cycles starting at k=1 and apply scheduled input actions.
    task automatic mon(input int ncyc);
        logic p_sclk, p_csn, p_bend, p_park;
        csn_first = -1; csn_last = -1; csn_rise_k = -1; csn_fall2_k = -1;
        rise_first = -1; rises = 0; done_k = -1; done_cnt = 0; ready_k = -1;
        mosi_viol = 0; busy_cnt = 0; bend_k = -1; park_fall_k = -1;
        cap = 32'h0; rst_snap = 11'h7ff;
        p_sclk = spi_sclk; p_csn = spi_csn; p_bend = bend; p_park = park;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) tick();
            if (!spi_csn) begin
                if (csn_first < 0) csn_first = k;
                if (csn_rise_k < 0) csn_last = k;
            end
            if (spi_csn && !p_csn && csn_rise_k < 0) csn_rise_k = k;
            if (!spi_csn && p_csn && csn_rise_k >= 0 && csn_fall2_k < 0) csn_fall2_k = k;
            if (spi_sclk && !p_sclk) begin
                rises++;
                if (rise_first < 0) rise_first = k;
                cap = {cap[30:0], spi_mosi};
            end
            if (spi_csn && spi_mosi) mosi_viol++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (cmd_ready && ready_k < 0) ready_k = k;
            if (bend != p_bend && bend_k < 0) bend_k = k;
            if (p_park && !park && park_fall_k < 0) park_fall_k = k;
            if (k == act_rst_k + 1)
                rst_snap = {spi_csn, spi_sclk, spi_mosi, park, bend, cmd_ready, busy, done,
                            spi_violated, close2overheat, overheat};
            p_sclk = spi_sclk; p_csn = spi_csn; p_bend = bend; p_park = park;
            if (k == act_speed_k) cmd_speed = act_speed_val;
            if (k == act_drop_valid_k) cmd_valid = 1'b0;
            if (k == act_bend_k) bend_req = ~bend_req;
            if (k == act_park_k) park_req = 1'b0;
            if (k == act_rst_k) rst = 1'b1;
            if (act_rst_k >= 0 && k == act_rst_k + 3) rst = 1'b0;
        end
    endtask

    initial begin
        clear_acts();
        // Reset values, with status pins high to show the synchronisers are cleared.
        fault = 1'b1; fan = 1'b1; dev_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_outs", {spi_csn, spi_sclk, spi_mosi, park, bend, cmd_ready, busy, done,
                              spi_violated, close2overheat, overheat}, 11'b100_0000_0000);
        rst = 1'b0; fault = 1'b0; fan = 1'b0; dev_ready = 1'b0; park_req = 1'b1;
        tick();
        check_eq("park_up", {park, cmd_ready}, 2'b11);
        repeat (3) tick();

        // Single frame 16'hA5C3.
        send_accept(16'hA5C3, 1'b0, ok);
        mon(140);
        check_eq("a5c3_csn_first", csn_first, 1);
        check_eq("a5c3_csn_last", csn_last, 132);
        check_eq("a5c3_rise_first", rise_first, 5);
        check_eq("a5c3_rises", rises, 16);
        check_eq("a5c3_data", cap[15:0], 16'hA5C3);
        check_eq("a5c3_done_k", done_k, 133);
        check_eq("a5c3_done_cnt", done_cnt, 1);
        check_eq("a5c3_ready_k", ready_k, 137);
        check_eq("a5c3_busy_cnt", busy_cnt, 136);
        check_eq("a5c3_mosi_idle", mosi_viol, 0);

        // Back-to-back 16'h0001 then 16'hFFFF with cmd_valid held.
        clear_acts();
        act_speed_k = 1; act_speed_val = 16'hFFFF; act_drop_valid_k = 200;
        send_accept(16'h0001, 1'b1, ok);
        mon(280);
        check_eq("b2b_rises", rises, 32);
        check_eq("b2b_data", cap, 32'h0001_FFFF);
        check_eq("b2b_done_cnt", done_cnt, 2);
        check_eq("b2b_gap_ge4", (csn_fall2_k - csn_rise_k) >= 4, 1'b1);
        check_eq("b2b_mosi_idle", mosi_viol, 0);

        // bend_req toggled and park_req dropped mid-frame.
        clear_acts();
        act_bend_k = 50; act_park_k = 50;
        send_accept(16'h3C5A, 1'b0, ok);
        mon(140);
        check_eq("bp_data", cap[15:0], 16'h3C5A);
        check_eq("bp_done_k", done_k, 133);
        check_eq("bp_bend_k", bend_k, 134);
        check_eq("bp_park_fall_k", park_fall_k, 134);
        check_eq("bp_no_ready", ready_k, -1);

        // Command held off while park is low, then started by raising park_req.
        clear_acts();
        cmd_speed = 16'h5A5A; cmd_valid = 1'b1;
        begin
            int rdy_seen, sclk_seen, csn_seen;
            rdy_seen = 0; sclk_seen = 0; csn_seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (cmd_ready) rdy_seen++;
                if (spi_sclk) sclk_seen++;
                if (!spi_csn) csn_seen++;
            end
            check_eq("holdoff_ready", rdy_seen, 0);
            check_eq("holdoff_sclk", sclk_seen, 0);
            check_eq("holdoff_csn", csn_seen, 0);
        end
        park_req = 1'b1;
        send_accept(16'h5A5A, 1'b0, ok);
        mon(140);
        check_eq("unpark_data", cap[15:0], 16'h5A5A);
        check_eq("unpark_done_k", done_k, 133);

        // Reset pulse mid-frame.
        clear_acts();
        act_rst_k = 60;
        send_accept(16'hC3A5, 1'b0, ok);
        mon(100);
        check_eq("midrst_outs", rst_snap, 11'b100_0000_0000);
        check_eq("midrst_csn_last", csn_last, 60);
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("midrst_mosi_idle", mosi_viol, 0);

        // Status synchronisers: two-cycle latency.
        fault = 1'b1; fan = 1'b0; dev_ready = 1'b1;
        tick();
        check_eq("sync_lat1", {spi_violated, close2overheat, overheat}, 3'b000);
        tick();
        check_eq("sync_lat2", {spi_violated, close2overheat, overheat}, 3'b101);
        fault = 1'b0; fan = 1'b1; dev_ready = 1'b0;
        tick();
        check_eq("sync_hold", {spi_violated, close2overheat, overheat}, 3'b101);
        tick();
        check_eq("sync_new", {spi_violated, close2overheat, overheat}, 3'b010);
        fan = 1'b0;
        repeat (3) tick();

        // Same word twice.
        clear_acts();
        send_accept(16'h1234, 1'b0, ok);
        mon(140);
        check_eq("dup1_data", cap[15:0], 16'h1234);
        check_eq("dup1_done_k", done_k, 133);
        send_accept(16'h1234, 1'b0, ok);
        mon(140);
`ifdef PMD901_SPI_CTRL_DEDUP_EN
        check_eq("dup2_no_frame", csn_first, -1);
        check_eq("dup2_done_k", done_k, 1);
        check_eq("dup2_done_cnt", done_cnt, 1);
        check_eq("dup2_busy", busy_cnt, 0);
        check_eq("dup2_ready_k", ready_k, 1);
`else
        check_eq("dup2_csn_first", csn_first, 1);
        check_eq("dup2_rises", rises, 16);
        check_eq("dup2_data", cap[15:0], 16'h1234);
        check_eq("dup2_done_k", done_k, 133);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
